// File: rtl/alex_spi_ctrl_pkg.sv
// Shared Alex definitions: serial word layout and SPI sequencer state encoding.
// The TX-side filter controller uses the same word layout.
package alex_spi_ctrl_pkg;

  localparam int ALEX_WORD_W = 16;
  localparam int BIT_TX      = 15;
  localparam int BIT_ATT_LO  = 13;
  localparam int BIT_HPF_LO  = 7;
  localparam int BIT_LPF_LO  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_LATCH,
    ST_GAP
  } state_t;

  function automatic logic [ALEX_WORD_W-1:0] pack_word(
    input logic       tx,
    input logic [1:0] atten,
    input logic [5:0] hpf,
    input logic [6:0] lpf
  );
    logic [ALEX_WORD_W-1:0] w;
    w = '0;
    w[BIT_TX]            = tx;
    w[BIT_ATT_LO +: 2]   = atten;
    w[BIT_HPF_LO +: 6]   = hpf;
    w[BIT_LPF_LO +: 7]   = lpf;
    return w;
  endfunction

endpackage

// File: rtl/spi_halfclk_timer.sv
// Half-period timer: loadable down-counter, terminal pulse at zero and a
// one-cycle-early pulse so callers can register outputs for the final cycle.
module spi_halfclk_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_load,
  output logic o_tc,
  output logic o_pre_tc
);

  logic [7:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= 8'(CLK_DIV - 1);
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_tc     = (r_cnt == 8'd0);
  assign o_pre_tc = (r_cnt == 8'd1);

endmodule

// File: rtl/alex_spi_ctrl.sv
// Alex filter/attenuator serial loader: resends the control word whenever it
// changes or a refresh is requested, one transfer at a time.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for a changed word or a latched refresh
//   ST_LOW   | SPI_clock low, current MSB presented on SPI_data
//   ST_HIGH  | SPI_clock high, data held across the Alex rising edge
//   ST_LATCH | SPI_load high to transfer the chain into output registers
//   ST_GAP   | all SPI lines low; done on the final cycle
module alex_spi_ctrl
  import alex_spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = ALEX_WORD_W
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] HPF,
  input  logic [6:0] LPF,
  input  logic [1:0] atten,
  input  logic       tx,
  input  logic       refresh,
  output logic       SPI_clock,
  output logic       SPI_data,
  output logic       SPI_load,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);

  state_t            r_state;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] r_last;
  logic [WORD_W-1:0] r_shift;
  logic [3:0]        r_bit;
  logic              r_pend;
  logic              r_primed;

  logic [WORD_W-1:0] w_word;
  logic              w_req;
  logic              w_start;
  logic              w_tmr_load;
  logic              w_tc;
  logic              w_pre_tc;

  assign w_word = pack_word(tx, atten, HPF, LPF);

  // Word changes are judged at IDLE exit so a change-and-revert costs nothing;
  // r_primed holds off the first decision until r_word holds live inputs.
  assign w_req      = r_primed && (r_pend || (r_word != r_last));
  assign w_start    = (r_state == ST_IDLE) && w_req;
  assign w_tmr_load = (r_state == ST_IDLE) || w_tc;

  spi_halfclk_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_load   (w_tmr_load),
    .o_tc     (w_tc),
    .o_pre_tc (w_pre_tc)
  );

  // A refresh arriving on the start cycle itself wins and earns a resend.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_word   <= '0;
      r_pend   <= 1'b1;
      r_primed <= 1'b0;
    end else begin
      r_word   <= w_word;
      r_pend   <= refresh | (r_pend & ~w_start);
      r_primed <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_last    <= '0;
      r_bit     <= '0;
      SPI_clock <= 1'b0;
      SPI_data  <= 1'b0;
      SPI_load  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (r_state == ST_GAP) && w_pre_tc;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_state   <= ST_LOW;
            r_shift   <= r_word;
            r_last    <= r_word;
            r_bit     <= '0;
            SPI_clock <= 1'b0;
            SPI_data  <= r_word[WORD_W-1];
            busy      <= 1'b1;
          end
        end
        ST_LOW: begin
          if (w_tc) begin
            r_state   <= ST_HIGH;
            SPI_clock <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (w_tc) begin
            r_shift   <= {r_shift[WORD_W-2:0], r_shift[WORD_W-1]};
            SPI_clock <= 1'b0;
            if (r_bit == LAST_BIT) begin
              r_state  <= ST_LATCH;
              SPI_data <= 1'b0;
              SPI_load <= 1'b1;
            end else begin
              r_state  <= ST_LOW;
              r_bit    <= r_bit + 4'd1;
              SPI_data <= r_shift[WORD_W-2];
            end
          end
        end
        ST_LATCH: begin
          if (w_tc) begin
            r_state  <= ST_GAP;
            SPI_load <= 1'b0;
          end
        end
        ST_GAP: begin
          if (w_tc) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alex_spi_ctrl.sv
// Bench for alex_spi_ctrl: transfer-level reference model with per-cycle
// output comparison, directed scenarios and a randomized soak.
module tb_alex_spi_ctrl;

  localparam int D    = 4;
  localparam int XFER = 34 * D;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] HPF     = 6'b010000;
  logic [6:0] LPF     = 7'h01;
  logic [1:0] atten   = 2'b00;
  logic       tx      = 1'b0;
  logic       refresh = 1'b0;
  logic       SPI_clock, SPI_data, SPI_load, busy, done;

  int checks = 0;
  int errors = 0;

  alex_spi_ctrl #(.CLK_DIV(D)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .HPF       (HPF),
    .LPF       (LPF),
    .atten     (atten),
    .tx        (tx),
    .refresh   (refresh),
    .SPI_clock (SPI_clock),
    .SPI_data  (SPI_data),
    .SPI_load  (SPI_load),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  // Reference model: word sampled one cycle late, transfer is a 34*D-cycle
  // window indexed by k, decision made on the first idle cycle.
  logic [15:0] m_word = '0, m_last = '0, m_snap = '0;
  logic        m_pend = 1'b1, m_primed = 1'b0, m_active = 1'b0;
  int          m_k = 0, m_cyc = 0;
  logic [15:0] m_log[$];
  int          m_start[$];

  function automatic logic [15:0] word_of();
    return 16'(int'(tx) * 32768 + int'(atten) * 8192 + int'(HPF) * 128 + int'(LPF));
  endfunction

  always @(posedge clock or negedge reset_n) begin
    bit start;
    if (!reset_n) begin
      if (m_active) void'(m_start.pop_back());
      m_word = '0; m_last = '0; m_snap = '0;
      m_pend = 1'b1; m_primed = 1'b0; m_active = 1'b0; m_k = 0;
    end else begin
      start = 1'b0;
      if (m_active) begin
        if (m_k == XFER - 1) begin
          m_active = 1'b0;
          m_log.push_back(m_snap);
        end else begin
          m_k++;
        end
      end else if (m_primed && (m_pend || m_word != m_last)) begin
        start = 1'b1; m_active = 1'b1; m_k = 0;
        m_snap = m_word; m_last = m_word;
        m_start.push_back(m_cyc);
      end
      m_pend   = refresh || (m_pend && !start);
      m_word   = word_of();
      m_primed = 1'b1;
      m_cyc++;
    end
  end

  // {SPI_clock, SPI_data, SPI_load, busy, done}
  function automatic logic [4:0] exp_vec();
    logic [4:0] v;
    v = 5'b0;
    if (m_active) begin
      v[1] = 1'b1;
      if (m_k < 32 * D) begin
        v[4] = ((m_k / D) % 2) == 1;
        v[3] = m_snap[4'(15 - m_k / (2 * D))];
      end else if (m_k < 33 * D) begin
        v[2] = 1'b1;
      end else begin
        v[0] = (m_k == XFER - 1);
      end
    end
    return v;
  endfunction

  function automatic logic [4:0] exp_mask();
    if (m_active && m_k >= 32 * D && m_k < 33 * D) return 5'b10111;
    return 5'b11111;
  endfunction

  always @(negedge clock) begin
    logic [4:0] e, m, a;
    e = exp_vec();
    m = exp_mask();
    a = {SPI_clock, SPI_data, SPI_load, busy, done};
    checks++;
    if ((a & m) !== (e & m)) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t k=%0d active=%0b actual=%b required=%b mask=%b",
               $time, m_k, m_active, a, e, m);
    end
  end

  // Pin-level capture of what Alex would actually latch.
  logic [15:0] cap_sh = '0;
  logic        p_clk = 1'b0, p_load = 1'b0, p_busy = 1'b0;
  logic [15:0] cap_q[$];
  int          dut_start[$];
  int          tb_cyc = 0, clk_toggles = 0, busy_cycles = 0, n_loads = 0;

  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_sh = '0; p_clk = 1'b0; p_load = 1'b0; p_busy = 1'b0;
    end else begin
      tb_cyc++;
      if (SPI_clock != p_clk) clk_toggles++;
      if (SPI_clock && !p_clk) cap_sh = {cap_sh[14:0], SPI_data};
      if (SPI_load && !p_load) begin
        cap_q.push_back(cap_sh);
        n_loads++;
      end
      if (busy && !p_busy) dut_start.push_back(tb_cyc);
      if (busy) busy_cycles++;
      p_clk = SPI_clock; p_load = SPI_load; p_busy = busy;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    @(negedge clock);
    refresh = 1'b0;
  endtask

  task automatic wait_k(input int kt);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (m_active && m_k == kt) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("wait_k_%0d_reached", kt), ok, 1);
  endtask

  task automatic wait_idle();
    int  run;
    bit  ok;
    run = 0;
    ok  = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      run = (m_active || busy) ? 0 : run + 1;
      if (run >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle_reached", ok, 1);
  endtask

  initial begin
    int n, loads, n0, l0, t0, b0;
    bit seen;

    // Reset and first transfer of the live word {0,00,010000,0000001} = 0801
    cyc(3);
    check("reset_outputs", {SPI_clock, SPI_data, SPI_load, busy, done}, 0);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    check("first_busy_seen", seen, 1);
    n = 1; loads = 0;
    while (!done && n < 300) begin
      if (SPI_load) loads++;
      @(negedge clock);
      n++;
    end
    check("done_cycle_after_start", n, 136);
    check("load_high_cycles", loads, 4);
    wait_idle();
    check("model_first_count", m_log.size(), 1);
    check("model_first_word", m_log[0], 16'h0801);
    check("dut_first_count", cap_q.size(), 1);
    check("dut_first_word", cap_q[0], 16'h0801);

    // Steady inputs: no activity
    t0 = clk_toggles; b0 = busy_cycles; n0 = m_log.size();
    cyc(1000);
    check("idle_clk_toggles", clk_toggles - t0, 0);
    check("idle_busy_cycles", busy_cycles - b0, 0);
    check("idle_model_xfers", m_log.size(), n0);

    // Change at bit 5: snapshot unaffected, follow-up one cycle after IDLE
    n0 = m_log.size(); l0 = dut_start.size();
    pulse_refresh();
    wait_k(40);
    HPF = 6'b001000;
    wait_idle();
    check("mid_change_count", m_log.size(), n0 + 2);
    check("mid_change_first", m_log[n0], 16'h0801);
    check("mid_change_second", m_log[n0 + 1], 16'h0401);
    check("mid_change_model_gap", m_start[n0 + 1] - m_start[n0], XFER + 1);
    check("mid_change_dut_first", cap_q[n0], 16'h0801);
    check("mid_change_dut_second", cap_q[n0 + 1], 16'h0401);
    check("mid_change_dut_gap", dut_start[l0 + 1] - dut_start[l0], XFER + 1);

    // Three changes in one transfer coalesce
    n0 = m_log.size();
    pulse_refresh();
    wait_k(10);  HPF = 6'b000001;
    wait_k(50);  HPF = 6'b000010;
    wait_k(90);  HPF = 6'b000100;
    wait_idle();
    check("coalesce_count", m_log.size(), n0 + 2);
    check("coalesce_last", m_log[n0 + 1], 16'h0201);
    check("coalesce_dut_count", cap_q.size(), n0 + 2);
    check("coalesce_dut_last", cap_q[n0 + 1], 16'h0201);

    // Refresh with unchanged inputs repeats the word
    n0 = m_log.size();
    pulse_refresh();
    wait_idle();
    check("refresh_count", m_log.size(), n0 + 1);
    check("refresh_dut_word", cap_q[n0], 16'h0201);

    // Refresh and change together: single transfer
    n0 = m_log.size();
    HPF = 6'b100000;
    pulse_refresh();
    wait_idle();
    check("refresh_change_count", m_log.size(), n0 + 1);
    check("refresh_change_dut_count", cap_q.size(), n0 + 1);
    check("refresh_change_dut_word", cap_q[n0], 16'h1001);

    // Change then revert inside a transfer: no follow-up
    n0 = m_log.size();
    pulse_refresh();
    wait_k(20);  HPF = 6'b000001;
    wait_k(60);  HPF = 6'b100000;
    wait_idle();
    check("revert_count", m_log.size(), n0 + 1);
    check("revert_dut_count", cap_q.size(), n0 + 1);

    // Reset in HIGH of bit 9, then resend of the live word D001
    n0 = m_log.size();
    tx = 1'b1; atten = 2'b10;
    wait_k(77);
    l0 = n_loads;
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs", {SPI_clock, SPI_data, SPI_load, busy, done}, 0);
    @(negedge clock);
    check("abort_no_load", n_loads, l0);
    check("abort_not_logged", m_log.size(), n0);
    reset_n = 1'b1;
    wait_idle();
    check("post_reset_count", m_log.size(), n0 + 1);
    check("post_reset_model_word", m_log[n0], 16'hD001);
    check("post_reset_dut_word", cap_q[n0], 16'hD001);

    // Randomized soak
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 39) == 0) {tx, atten, HPF, LPF} = 16'($urandom);
      refresh = ($urandom_range(0, 59) == 0);
    end
    refresh = 1'b0;
    wait_idle();

    check("final_word_count", cap_q.size(), m_log.size());
    for (int i = 0; i < cap_q.size() && i < m_log.size(); i++)
      check($sformatf("final_word_%0d", i), cap_q[i], m_log[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
